bp_me_ct_credit_receiver: RTL and testbench
===========================================

Name: bp_me_ct_credit_receiver

Overview:
- Receive-side endpoint of the credit-tokened (ct) link used between tiles and the memory NoC.
- The transmitter is gated by `ct_remote_credits` credits. This block buffers incoming flits in a FIFO sized to exactly that credit count.
- It presents the buffered flits to the local consumer over valid/yumi.
- It returns credits to the transmitter in decimated tokens: one `credit_v_o` pulse per 2^`lg_credit_decimation` flits consumed.

Parameters:
- `flit_width_p`, 62, width of one link flit (matches `coh_noc_flit_width`).
- `remote_credits_p`, 32, FIFO depth; equals the transmitter's initial credit count. Must be a power of 2 and ≥ 2^`lg_credit_decimation_p`.
- `lg_credit_decimation_p`, 3, log2 of the number of flits represented by one returned credit token.

Ports:
- `clk_i`, in, 1, the single clock.
- `reset_n_i`, in, 1, asynchronous active-low reset.
- `link_v_i`, in, 1, flit valid from the link (valid-only; no ready).
- `link_data_i`, in, `flit_width_p`, flit payload.
- `v_o`, out, 1, head flit valid to the consumer.
- `data_o`, out, `flit_width_p`, head flit payload.
- `yumi_i`, in, 1, consumer dequeues the head flit this cycle. Legal only when `v_o` is high.
- `credit_v_o`, out, 1, one-cycle pulse returning 2^`lg_credit_decimation_p` credits.
- `occupancy_o`, out, clog2(`remote_credits_p`+1), number of buffered flits.
- `overflow_o`, out, 1, sticky error: a flit arrived with no free slot.

Behaviour:
- **Reset** (asynchronous assert, synchronous release):
  - Read pointer, write pointer and occupancy are 0.
  - Decimation counter is 0.
  - `v_o`=0, `credit_v_o`=0, `overflow_o`=0, `occupancy_o`=0.
  - `data_o` is don't-care.
- **Storage:** circular buffer of `remote_credits_p` entries. Pointers are clog2(`remote_credits_p`) bits and wrap naturally from `remote_credits_p`-1 to 0.
- **Enqueue:** `link_v_i`=1 and (occupancy < `remote_credits_p` OR `yumi_i`=1) → write at the write pointer and increment it.
- **Latency:** no bypass. A flit arriving into an empty FIFO drives `v_o`=1 on the following cycle.
- **Outputs:** `v_o` = (occupancy != 0). `data_o` = entry at the read pointer, combinational from storage.
- **Dequeue:** `yumi_i`=1 → increment the read pointer.
  - `yumi_i` while `v_o`=0 is illegal. The design ignores it: no pointer or counter change. An assertion fires in simulation.
- **Occupancy update:**
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue, including when full.
- **Overflow:** `link_v_i`=1 while full with `yumi_i`=0 → the flit is dropped, no pointer changes, and `overflow_o` is set to 1. It stays 1 until reset.
- **Credit return:**
  - A `lg_credit_decimation_p`-bit counter increments on each legal dequeue and wraps to 0.
  - On a dequeue that takes the counter from all-ones to 0, `credit_v_o` pulses for exactly one cycle, starting the next cycle (registered).
  - Back-to-back dequeues can never produce two pulses in adjacent cycles unless `lg_credit_decimation_p`=0. In that case `credit_v_o` is a registered copy of the legal `yumi_i`.
- **Partial counts:** consumed flits not yet covered by a token remain held in the counter. No timeout flush.
- **Credit conservation:** after N total dequeues, the number of pulses is floor(N / 2^`lg_credit_decimation_p`).
- **Reset mid-operation:** immediately discards all buffered flits and the partial credit count. The transmitter is reset by the same reset, so credits re-synchronise.

Test Plan:
- **Empty-FIFO latency:** reset, then 1 flit 0xABC with `yumi_i` held 0 → `v_o`=0 in the arrival cycle; `v_o`=1 and `data_o`=0xABC the next cycle; `occupancy_o`=1.
- **Order and wrap:** 32 flits (values 0–31) with no dequeue → `occupancy_o`=32. Dequeue all → values in order 0..31, then `v_o`=0. Repeat with 40 flits interleaved with dequeues → order preserved across the pointer wrap.
- **Decimation:** with `lg`=3, dequeue 8 flits → exactly one `credit_v_o` pulse, in the cycle after the 8th `yumi_i`. Dequeue 7 more → no pulse. 1 more → a second pulse. Total 2 pulses for 16 dequeues.
- **Full boundary:** fill to 32; `link_v_i`=1 with `yumi_i`=1 in the same cycle → no overflow, occupancy stays 32, new flit appears after 31 older ones. `link_v_i`=1 with `yumi_i`=0 when full → `overflow_o`=1, sticky, flit discarded.
- **Reset mid-stream:** after 5 buffered flits and a counter value of 5, assert `reset_n_i`=0 asynchronously mid-cycle → `v_o`, `occupancy_o`, `credit_v_o` go to 0 immediately. After release, 8 new dequeues produce exactly 1 pulse.
- **Random traffic with a credit-obeying transmitter model** (32 credits, refilled by 8 per pulse), 10k cycles → no overflow, FIFO-ordered data, transmitter credits return to 32 once idle and the flit total is a multiple of 8.

Source files
------------

// File: rtl/bp_me_ct_credit_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_me_ct_credit_receiver: credit-tokened link receive FIFO with          |
// | decimated credit return.  Rev 1.0                                        |
// +--------------------------------------------------------------------------+
module bp_me_ct_credit_receiver #(
    parameter int flit_width_p           = 62,
    parameter int remote_credits_p       = 32,
    parameter int lg_credit_decimation_p = 3
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   link_v_i,
    input  logic [flit_width_p-1:0]                link_data_i,
    output logic                                   v_o,
    output logic [flit_width_p-1:0]                data_o,
    input  logic                                   yumi_i,
    output logic                                   credit_v_o,
    output logic [$clog2(remote_credits_p+1)-1:0]  occupancy_o,
    output logic                                   overflow_o
);

    localparam int PTR_W = (remote_credits_p > 1) ? $clog2(remote_credits_p) : 1;
    localparam int OCC_W = $clog2(remote_credits_p + 1);

    logic [flit_width_p-1:0] mem_q [remote_credits_p];
    logic [PTR_W-1:0]        rptr_q, rptr_d;
    logic [PTR_W-1:0]        wptr_q, wptr_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic                    overflow_q, overflow_d;
    logic                    credit_q, credit_d;
    logic                    w_full, w_deq, w_enq;

    // An illegal yumi on an empty FIFO is masked so state cannot corrupt.
    assign w_full = (occ_q == OCC_W'(remote_credits_p));
    assign w_deq  = yumi_i & (occ_q != '0);
    assign w_enq  = link_v_i & (~w_full | w_deq);

    always_comb begin
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q | (link_v_i & w_full & ~w_deq);
        if (w_deq) rptr_d = rptr_q + PTR_W'(1);
        if (w_enq) wptr_d = wptr_q + PTR_W'(1);
        if (w_enq & ~w_deq)      occ_d = occ_q + OCC_W'(1);
        else if (w_deq & ~w_enq) occ_d = occ_q - OCC_W'(1);
    end

    generate
        if (lg_credit_decimation_p == 0) begin : g_nodec
            assign credit_d = w_deq;
        end else begin : g_dec
            logic [lg_credit_decimation_p-1:0] cnt_q;
            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i)  cnt_q <= '0;
                else if (w_deq)  cnt_q <= cnt_q + lg_credit_decimation_p'(1);
            end
            assign credit_d = w_deq & (&cnt_q);
        end
    endgenerate

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q     <= '0;
            wptr_q     <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
            credit_q   <= 1'b0;
        end else begin
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
            credit_q   <= credit_d;
        end
    end

    // Storage carries no reset; validity is tracked by occupancy alone.
    always_ff @(posedge clk_i) begin
        if (w_enq) mem_q[wptr_q] <= link_data_i;
    end

    assign v_o         = (occ_q != '0);
    assign data_o      = mem_q[rptr_q];
    assign credit_v_o  = credit_q;
    assign occupancy_o = occ_q;
    assign overflow_o  = overflow_q;

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                   yumi_i |-> (occ_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_bp_me_ct_credit_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bp_me_ct_credit_receiver: directed and credit-model traffic bench.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_bp_me_ct_credit_receiver;

    localparam int FW = 62;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          link_v;
    logic [FW-1:0] link_data;
    logic          v;
    logic [FW-1:0] data;
    logic          yumi;
    logic          credit_v;
    logic [5:0]    occ;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    bp_me_ct_credit_receiver #(
        .flit_width_p(FW), .remote_credits_p(32), .lg_credit_decimation_p(3)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .link_v_i(link_v), .link_data_i(link_data),
        .v_o(v), .data_o(data), .yumi_i(yumi), .credit_v_o(credit_v),
        .occupancy_o(occ), .overflow_o(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge and tally returned tokens.
    task automatic tick();
        @(posedge clk);
        #1;
        if (credit_v) pulses++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; link_v = 1'b0; yumi = 1'b0; link_data = '0;
        repeat (2) tick();
        @(negedge clk) reset_n = 1'b1;
        tick();
        pulses = 0;
    endtask

    task automatic push(input logic [FW-1:0] val);
        link_v = 1'b1; link_data = val;
        tick();
        link_v = 1'b0;
    endtask

    task automatic pop(input string tag, input logic [FW-1:0] exp);
        chk({tag, "_v"}, 64'(v), 64'd1);
        chk({tag, "_data"}, 64'(data), 64'(exp));
        yumi = 1'b1;
        tick();
        yumi = 1'b0;
    endtask

    logic [FW-1:0] q[$];
    int tx_cred, sent, p0, nxt, rd;

    initial begin
        // Reset values
        reset_n = 1'b0; link_v = 1'b0; yumi = 1'b0; link_data = '0;
        #12;
        chk("rst_v", 64'(v), 0);
        chk("rst_occ", 64'(occ), 0);
        chk("rst_credit", 64'(credit_v), 0);
        chk("rst_overflow", 64'(overflow), 0);
        do_reset();

        // Empty-FIFO latency
        link_v = 1'b1; link_data = FW'('hABC);
        #0 chk("lat_v_arrival", 64'(v), 0);
        tick();
        link_v = 1'b0;
        chk("lat_v_next", 64'(v), 1);
        chk("lat_data", 64'(data), 64'hABC);
        chk("lat_occ", 64'(occ), 1);

        // Order and wrap: fill to 32, drain, then interleave 40 flits
        do_reset();
        for (int i = 0; i < 32; i++) push(FW'(i));
        chk("fill_occ", 64'(occ), 32);
        for (int i = 0; i < 32; i++) pop("drain", FW'(i));
        chk("drain_v", 64'(v), 0);
        chk("drain_pulses", 64'(pulses), 4);
        nxt = 100; rd = 100;
        for (int i = 0; i < 40; i++) begin
            link_v = 1'b1; link_data = FW'(nxt); nxt++;
            yumi = v;
            if (v) begin chk("wrap_data", 64'(data), 64'(rd)); rd++; end
            tick();
        end
        link_v = 1'b0; yumi = 1'b0;
        while (v && rd < 140) pop("wrap_tail", FW'(rd++));
        chk("wrap_count", 64'(rd), 140);
        chk("wrap_empty", 64'(v), 0);

        // Decimation: pulse only after the 8th and 16th dequeues
        do_reset();
        for (int i = 0; i < 16; i++) push(FW'(i + 7));
        for (int i = 0; i < 16; i++) begin
            pop("dec", FW'(i + 7));
            chk($sformatf("dec_credit%0d", i + 1), 64'(credit_v), (i == 7 || i == 15) ? 1 : 0);
        end
        tick();
        chk("dec_pulse_width", 64'(credit_v), 0);
        chk("dec_total", 64'(pulses), 2);

        // Full boundary and sticky overflow
        do_reset();
        for (int i = 0; i < 32; i++) push(FW'(i));
        link_v = 1'b1; link_data = FW'('h55); yumi = 1'b1;
        tick();
        link_v = 1'b0; yumi = 1'b0;
        chk("full_swap_ovf", 64'(overflow), 0);
        chk("full_swap_occ", 64'(occ), 32);
        push(FW'('h77));
        chk("full_drop_ovf", 64'(overflow), 1);
        chk("full_drop_occ", 64'(occ), 32);
        for (int i = 1; i < 32; i++) pop("full_order", FW'(i));
        pop("full_new", FW'('h55));
        chk("full_dropped_gone", 64'(v), 0);
        chk("full_ovf_sticky", 64'(overflow), 1);

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 10; i++) push(FW'(i));
        for (int i = 0; i < 5; i++) pop("mid", FW'(i));
        chk("mid_occ_pre", 64'(occ), 5);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_v", 64'(v), 0);
        chk("mid_occ", 64'(occ), 0);
        chk("mid_credit", 64'(credit_v), 0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        pulses = 0;
        for (int i = 0; i < 8; i++) push(FW'(i + 200));
        for (int i = 0; i < 8; i++) pop("mid_after", FW'(i + 200));
        tick();
        chk("mid_pulses", 64'(pulses), 1);

        // Random traffic against a credit-obeying transmitter model
        do_reset();
        tx_cred = 32; sent = 0; q.delete();
        for (int c = 0; c < 10000; c++) begin
            link_v = (tx_cred > 0) && ($urandom_range(0, 3) != 0);
            link_data = {$urandom, $urandom};
            if (link_v) begin tx_cred--; sent++; q.push_back(link_data); end
            yumi = v && ($urandom_range(0, 2) != 0);
            if (yumi) begin
                if (q.size() == 0) chk("rnd_underflow", 64'(v), 0);
                else chk("rnd_data", 64'(data), 64'(q.pop_front()));
            end
            p0 = pulses;
            tick();
            if (pulses != p0) tx_cred += 8;
        end
        for (int c = 0; c < 500; c++) begin
            link_v = (sent % 8 != 0) && (tx_cred > 0);
            link_data = {$urandom, $urandom};
            if (link_v) begin tx_cred--; sent++; q.push_back(link_data); end
            yumi = v;
            if (yumi) begin
                if (q.size() == 0) chk("rnd_underflow", 64'(v), 0);
                else chk("rnd_drain_data", 64'(data), 64'(q.pop_front()));
            end
            p0 = pulses;
            tick();
            if (pulses != p0) tx_cred += 8;
        end
        link_v = 1'b0; yumi = 1'b0;
        chk("rnd_multiple8", 64'(sent % 8), 0);
        chk("rnd_tx_credits", 64'(tx_cred), 32);
        chk("rnd_overflow", 64'(overflow), 0);
        chk("rnd_occ", 64'(occ), 0);
        chk("rnd_model_empty", 64'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
